fpu_issue_ctrl: RTL and testbench

Issue sequencer on the initiating side of the floating-point adder's start/done handshake. It accepts FADD.S/FSUB.S requests from the RISC-V pipeline over valid/ready and drives operands and a level `start` to the adder. It waits for `done`, then releases `start` and waits for `done` to fall. It returns the result, tagged with its destination register, over a second valid/ready channel, and aborts with a timeout response if the adder never answers.

---
 rtl/fpu_issue_ctrl_if.sv | 42 ++++
 rtl/fpu_issue_ctrl.sv | 94 +++++++++
 tb/tb_fpu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - request, adder and response channels of the FP add issue sequencer
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;

    logic        fpu_start;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_rd,
        input  fpu_done, fpu_result,
        input  rsp_ready,
        output req_ready,
        output fpu_start, fpu_a, fpu_b,
        output rsp_valid, rsp_result, rsp_rd, rsp_timeout,
        output busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_rd,
        output fpu_done, fpu_result,
        output rsp_ready,
        input  req_ready,
        input  fpu_start, fpu_a, fpu_b,
        input  rsp_valid, rsp_result, rsp_rd, rsp_timeout,
        input  busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - issues FADD.S/FSUB.S to the adder over start/done, returns tagged result or timeout
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_issue_ctrl_if.master  bus
);
    localparam int unsigned     CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   result_q;
    logic [4:0]    rd_q;
    logic          timeout_q;
    logic          req_ready_w;

    // A late done from an aborted op must drain before the adder is reused.
    assign req_ready_w = rst_n && (state_q == S_IDLE) && !bus.fpu_done;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_w) begin
                        a_q     <= bus.req_a;
                        // Subtract is an add with B's sign inverted.
                        b_q     <= {bus.req_b[31] ^ bus.req_op, bus.req_b[30:0]};
                        rd_q    <= bus.req_rd;
                        cnt_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_d;
                    if (bus.fpu_done) begin
                        result_q  <= bus.fpu_result;
                        timeout_q <= 1'b0;
                        state_q   <= S_RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q  <= QNAN;
                        timeout_q <= 1'b1;
                        state_q   <= S_RESP;
                    end
                end
                S_RELEASE: begin
                    if (!bus.fpu_done) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_w;
    assign bus.fpu_start   = (state_q == S_ISSUE);
    assign bus.fpu_a       = a_q;
    assign bus.fpu_b       = b_q;
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_result  = result_q;
    assign bus.rsp_rd      = rd_q;
    assign bus.rsp_timeout = timeout_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed vector bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fpu_issue_ctrl_if ifc ();

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
        int          hold;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Full op: accept at cycle 0, done at cycle lat, done held hold cycles after start falls.
    task automatic run_op(input vec_t v);
        ifc.req_valid = 1'b1;
        ifc.req_op    = v.op;
        ifc.req_a     = v.a;
        ifc.req_b     = v.b;
        ifc.req_rd    = v.rd;
        chk_bit("idle_req_ready", ifc.req_ready, 1'b1);
        step();
        ifc.req_valid = 1'b0;
        ifc.req_a     = 32'hDEAD_BEEF;
        ifc.req_b     = 32'h0BAD_F00D;
        ifc.req_rd    = ~v.rd;
        for (int c = 1; c <= v.lat; c++) begin
            if (c == v.lat) begin
                ifc.fpu_done   = 1'b1;
                ifc.fpu_result = v.res;
            end
            chk_bit("issue_start", ifc.fpu_start, 1'b1);
            chk("issue_fpu_a", ifc.fpu_a, v.a);
            chk("issue_fpu_b", ifc.fpu_b, v.exp_b);
            chk_bit("issue_req_ready", ifc.req_ready, 1'b0);
            step();
        end
        for (int c = 0; c < v.hold; c++) begin
            chk_bit("release_start", ifc.fpu_start, 1'b0);
            chk_bit("release_rsp_valid", ifc.rsp_valid, 1'b0);
            chk_bit("release_req_ready", ifc.req_ready, 1'b0);
            step();
        end
        ifc.fpu_done   = 1'b0;
        ifc.fpu_result = 32'h5555_5555;
        chk_bit("drop_start", ifc.fpu_start, 1'b0);
        chk_bit("drop_rsp_valid", ifc.rsp_valid, 1'b0);
        chk_bit("drop_busy", ifc.busy, 1'b1);
        step();
        chk_bit("resp_valid", ifc.rsp_valid, 1'b1);
        chk("resp_result", ifc.rsp_result, v.res);
        chk("resp_rd", 32'(ifc.rsp_rd), 32'(v.rd));
        chk_bit("resp_timeout", ifc.rsp_timeout, 1'b0);
        chk_bit("resp_req_ready", ifc.req_ready, 1'b0);
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk_bit("post_rsp_valid", ifc.rsp_valid, 1'b0);
        chk_bit("post_busy", ifc.busy, 1'b0);
        chk_bit("post_req_ready", ifc.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{op:1'b0, a:32'h3F80_0000, b:32'h4000_0000, rd:5'd5,  res:32'h4040_0000, lat:6, hold:0, exp_b:32'h4000_0000};
        vecs[1] = '{op:1'b1, a:32'h4040_0000, b:32'h3F80_0000, rd:5'd7,  res:32'h4000_0000, lat:2, hold:0, exp_b:32'hBF80_0000};
        vecs[2] = '{op:1'b1, a:32'h4040_0000, b:32'hBF80_0000, rd:5'd9,  res:32'h4080_0000, lat:3, hold:3, exp_b:32'h3F80_0000};
        vecs[3] = '{op:1'b1, a:32'h3F80_0000, b:32'h0000_0000, rd:5'd31, res:32'h3F80_0000, lat:4, hold:1, exp_b:32'h8000_0000};
        vecs[4] = '{op:1'b0, a:32'h0000_0001, b:32'hFFFF_FFFF, rd:5'd0,  res:32'h1234_5678, lat:8, hold:0, exp_b:32'hFFFF_FFFF};
        vecs[5] = '{op:1'b1, a:32'hC000_0000, b:32'h7FFF_FFFF, rd:5'd16, res:32'hCAFE_0001, lat:1, hold:2, exp_b:32'hFFFF_FFFF};

        rst_n          = 1'b0;
        ifc.req_valid  = 1'b0;
        ifc.req_op     = 1'b0;
        ifc.req_a      = '0;
        ifc.req_b      = '0;
        ifc.req_rd     = '0;
        ifc.fpu_done   = 1'b0;
        ifc.fpu_result = '0;
        ifc.rsp_ready  = 1'b0;
        step();
        step();
        chk_bit("rst_start", ifc.fpu_start, 1'b0);
        chk_bit("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        chk_bit("rst_busy", ifc.busy, 1'b0);
        chk_bit("rst_req_ready", ifc.req_ready, 1'b0);
        chk("rst_fpu_a", ifc.fpu_a, 32'h0);
        chk("rst_fpu_b", ifc.fpu_b, 32'h0);
        chk("rst_rsp_result", ifc.rsp_result, 32'h0);
        chk("rst_rsp_rd", 32'(ifc.rsp_rd), 32'h0);
        chk_bit("rst_rsp_timeout", ifc.rsp_timeout, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_bit("rel_req_ready", ifc.req_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Timeout: start high for cycles 1..8, response at cycle 9.
        ifc.req_valid = 1'b1;
        ifc.req_op    = 1'b0;
        ifc.req_a     = 32'h1111_1111;
        ifc.req_b     = 32'h2222_2222;
        ifc.req_rd    = 5'd12;
        step();
        ifc.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk_bit("to_start_high", ifc.fpu_start, 1'b1);
            step();
        end
        chk_bit("to_start_low", ifc.fpu_start, 1'b0);
        chk_bit("to_rsp_valid", ifc.rsp_valid, 1'b1);
        chk("to_rsp_result", ifc.rsp_result, 32'h7FC0_0000);
        chk_bit("to_rsp_timeout", ifc.rsp_timeout, 1'b1);
        chk("to_rsp_rd", 32'(ifc.rsp_rd), 32'd12);
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk_bit("to_idle_busy", ifc.busy, 1'b0);
        // Stray late done must block issue until it falls.
        ifc.fpu_done  = 1'b1;
        ifc.req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_bit("stray_req_ready", ifc.req_ready, 1'b0);
            step();
            chk_bit("stray_busy", ifc.busy, 1'b0);
        end
        ifc.fpu_done = 1'b0;
        #1;
        chk_bit("stray_cleared_ready", ifc.req_ready, 1'b1);
        ifc.req_valid = 1'b0;
        step();
        chk_bit("stray_no_accept", ifc.busy, 1'b0);

        // Back-pressure with a second request waiting.
        ifc.req_valid = 1'b1;
        ifc.req_op    = 1'b0;
        ifc.req_a     = 32'hAAAA_0001;
        ifc.req_b     = 32'hBBBB_0001;
        ifc.req_rd    = 5'd3;
        step();
        ifc.req_a     = 32'hAAAA_0002;
        ifc.req_b     = 32'hBBBB_0002;
        ifc.req_rd    = 5'd4;
        ifc.fpu_done   = 1'b1;
        ifc.fpu_result = 32'h0000_0BB1;
        step();
        ifc.fpu_done   = 1'b0;
        ifc.fpu_result = 32'h0;
        chk_bit("bp_release_ready", ifc.req_ready, 1'b0);
        step();
        for (int c = 0; c < 10; c++) begin
            chk_bit("bp_rsp_valid", ifc.rsp_valid, 1'b1);
            chk("bp_rsp_result", ifc.rsp_result, 32'h0000_0BB1);
            chk("bp_rsp_rd", 32'(ifc.rsp_rd), 32'd3);
            chk_bit("bp_req_ready", ifc.req_ready, 1'b0);
            step();
        end
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk_bit("b2b_idle_busy", ifc.busy, 1'b0);
        chk_bit("b2b_idle_ready", ifc.req_ready, 1'b1);
        step();
        ifc.req_valid = 1'b0;
        chk_bit("b2b_start", ifc.fpu_start, 1'b1);
        chk("b2b_fpu_a", ifc.fpu_a, 32'hAAAA_0002);
        chk("b2b_fpu_b", ifc.fpu_b, 32'hBBBB_0002);
        ifc.fpu_done   = 1'b1;
        ifc.fpu_result = 32'h0000_0BB2;
        step();
        ifc.fpu_done = 1'b0;
        step();
        chk_bit("b2b_rsp_valid", ifc.rsp_valid, 1'b1);
        chk("b2b_rsp_result", ifc.rsp_result, 32'h0000_0BB2);
        chk("b2b_rsp_rd", 32'(ifc.rsp_rd), 32'd4);
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;

        // Reset asserted in cycle 3 of an op.
        ifc.req_valid = 1'b1;
        ifc.req_a     = 32'h7777_7777;
        ifc.req_b     = 32'h8888_8888;
        ifc.req_rd    = 5'd21;
        step();
        ifc.req_valid = 1'b0;
        step();
        step();
        chk_bit("mr_start_before", ifc.fpu_start, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("mr_start", ifc.fpu_start, 1'b0);
        chk_bit("mr_rsp_valid", ifc.rsp_valid, 1'b0);
        chk_bit("mr_busy", ifc.busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk_bit("mr_req_ready", ifc.req_ready, 1'b1);
        ifc.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk_bit("mr_no_rsp", ifc.rsp_valid, 1'b0);
            chk_bit("mr_no_busy", ifc.busy, 1'b0);
        end
        ifc.rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
